// File: rtl/npc_ctrl.sv
// Next-PC controller for the IF stage: arbitrates exception > ERET > branch > PC+4
// and holds a redirect that arrives while fetch is stalled. Optional macro: NPC_ALIGN_CHECK_EN.
module npc_ctrl #(
  parameter logic [31:0] PC_RST_ADDR = 32'hBFC0_0000,
  parameter logic [31:0] EXC_VECTOR  = 32'hBFC0_0380
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] if_pc,
  input  logic        if_stall,
  input  logic        br_valid,
  input  logic [31:0] br_target,
  input  logic        exc_valid,
  input  logic        eret_valid,
  input  logic [31:0] epc,
  output logic [31:0] if_npc,
  output logic        if_pcwr,
  output logic        if_flush,
  output logic        pend_valid
`ifdef NPC_ALIGN_CHECK_EN
  ,
  output logic        if_adel
`endif
);

  typedef enum logic [1:0] {ST_BOOT, ST_RUN, ST_PEND} state_e;
  // Encoded so that a numerically larger value always wins arbitration.
  typedef enum logic [1:0] {PRI_NONE, PRI_BR, PRI_ERET, PRI_EXC} pri_e;

  state_e      state_q, state_d;
  pri_e        pend_pri_q, pend_pri_d;
  logic [31:0] pend_tgt_q, pend_tgt_d;

  pri_e        new_pri;
  logic [31:0] new_tgt;
  logic        new_redir;
  logic        take_new;
  pri_e        res_pri;
  logic [31:0] res_tgt;

  // Fixed-priority pick among this cycle's redirect pulses; falls back to PC+4.
  always_comb begin
    if (exc_valid) begin
      new_pri = PRI_EXC;
      new_tgt = EXC_VECTOR;
    end else if (eret_valid) begin
      new_pri = PRI_ERET;
      new_tgt = epc;
    end else if (br_valid) begin
      new_pri = PRI_BR;
      new_tgt = br_target;
    end else begin
      new_pri = PRI_NONE;
      new_tgt = if_pc + 32'd4;
    end
  end

  assign new_redir = (new_pri != PRI_NONE);
  // Equal priority overwrites: the younger redirect of the same kind is the correct one.
  assign take_new  = new_redir && (new_pri >= pend_pri_q);
  assign res_pri   = take_new ? new_pri : pend_pri_q;
  assign res_tgt   = take_new ? new_tgt : pend_tgt_q;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_d    = state_q;
    pend_pri_d = pend_pri_q;
    pend_tgt_d = pend_tgt_q;
    if_npc     = PC_RST_ADDR;
    if_pcwr    = 1'b0;
    if_flush   = 1'b0;

    unique case (state_q)
      ST_BOOT: begin
        state_d = ST_RUN;
        if (new_redir) begin
          state_d    = ST_PEND;
          pend_pri_d = new_pri;
          pend_tgt_d = new_tgt;
        end
      end
      ST_RUN: begin
        if_npc = new_tgt;
        if (!if_stall) begin
          if_pcwr  = 1'b1;
          if_flush = new_redir;
        end else if (new_redir) begin
          state_d    = ST_PEND;
          pend_pri_d = new_pri;
          pend_tgt_d = new_tgt;
        end
      end
      ST_PEND: begin
        if_npc     = res_tgt;
        pend_pri_d = res_pri;
        pend_tgt_d = res_tgt;
        if (!if_stall) begin
          if_pcwr    = 1'b1;
          if_flush   = 1'b1;
          state_d    = ST_RUN;
          pend_pri_d = PRI_NONE;
        end
      end
      default: state_d = ST_BOOT;
    endcase

    if (rst) begin
      if_npc   = PC_RST_ADDR;
      if_pcwr  = 1'b0;
      if_flush = 1'b0;
    end
  end

  assign pend_valid = !rst && (state_q == ST_PEND);

`ifdef NPC_ALIGN_CHECK_EN
  // A flush marks a redirect write; sequential PC+4 is never flagged.
  assign if_adel = if_flush && (if_npc[1:0] != 2'b00);
`endif

  always_ff @(posedge clk) begin
    // NOTE: state flops use non-blocking assignment so every flop samples
    // pre-edge values regardless of statement order.
    if (rst) begin
      state_q    <= ST_BOOT;
      pend_pri_q <= PRI_NONE;
      pend_tgt_q <= '0;
    end else begin
      state_q    <= state_d;
      pend_pri_q <= pend_pri_d;
      pend_tgt_q <= pend_tgt_d;
    end
  end

endmodule

// File: tb/tb_npc_ctrl.sv
// Scoreboarded bench for npc_ctrl: directed scenarios followed by randomized traffic,
// checked against a redirect-ranking reference model.
module tb_npc_ctrl;

  localparam logic [31:0] RST_PC = 32'hBFC0_0000;
  localparam logic [31:0] EXC_PC = 32'hBFC0_0380;

  logic        clk;
  logic        rst;
  logic [31:0] if_pc;
  logic        if_stall;
  logic        br_valid;
  logic [31:0] br_target;
  logic        exc_valid;
  logic        eret_valid;
  logic [31:0] epc;
  logic [31:0] if_npc;
  logic        if_pcwr;
  logic        if_flush;
  logic        pend_valid;
`ifdef NPC_ALIGN_CHECK_EN
  logic        if_adel;
`endif

  npc_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .if_pc      (if_pc),
    .if_stall   (if_stall),
    .br_valid   (br_valid),
    .br_target  (br_target),
    .exc_valid  (exc_valid),
    .eret_valid (eret_valid),
    .epc        (epc),
    .if_npc     (if_npc),
    .if_pcwr    (if_pcwr),
    .if_flush   (if_flush),
    .pend_valid (pend_valid)
`ifdef NPC_ALIGN_CHECK_EN
    ,
    .if_adel    (if_adel)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        pcwr;
    logic        flush;
    logic        pend;
    logic        adel;
    logic        chk_npc;
    logic [31:0] npc;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: the DUT presents a result every cycle; compare mid-cycle.
  always @(negedge clk) begin
    if (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      check("if_pcwr", 32'(if_pcwr), 32'(e.pcwr));
      check("if_flush", 32'(if_flush), 32'(e.flush));
      check("pend_valid", 32'(pend_valid), 32'(e.pend));
      if (e.chk_npc) check("if_npc", if_npc, e.npc);
`ifdef NPC_ALIGN_CHECK_EN
      check("if_adel", 32'(if_adel), 32'(e.adel));
`endif
    end
  end

  // Reference model: a PC register plus at most one held redirect ranked 1..3.
  logic [31:0] pc_m;
  bit          m_boot;
  bit          m_held;
  int          m_rank;
  logic [31:0] m_tgt;

  task automatic step(input bit r, input bit st, input bit e, input bit er, input bit b,
                      input logic [31:0] bt, input logic [31:0] ep);
    exp_t        x;
    int          rank;
    logic [31:0] tgt;
    rst = r; if_stall = st; exc_valid = e; eret_valid = er; br_valid = b;
    br_target = bt; epc = ep; if_pc = pc_m;

    rank = e ? 3 : er ? 2 : b ? 1 : 0;
    tgt  = e ? EXC_PC : er ? ep : b ? bt : pc_m + 32'd4;
    x = '{pcwr: 1'b0, flush: 1'b0, pend: 1'b0, adel: 1'b0, chk_npc: 1'b0, npc: RST_PC};

    if (r) begin
      x.chk_npc = 1'b1;
      m_boot = 1'b1;
      m_held = 1'b0;
    end else if (m_boot) begin
      x.chk_npc = 1'b1;
      m_boot = 1'b0;
      if (rank > 0) begin m_held = 1'b1; m_rank = rank; m_tgt = tgt; end
    end else if (m_held) begin
      x.pend = 1'b1;
      if (rank > 0 && rank >= m_rank) begin m_rank = rank; m_tgt = tgt; end
      if (!st) begin
        x.pcwr = 1'b1; x.flush = 1'b1; x.chk_npc = 1'b1; x.npc = m_tgt;
        m_held = 1'b0;
        pc_m = m_tgt;
      end
    end else if (!st) begin
      x.pcwr = 1'b1; x.flush = (rank > 0); x.chk_npc = 1'b1; x.npc = tgt;
      pc_m = tgt;
    end else if (rank > 0) begin
      m_held = 1'b1; m_rank = rank; m_tgt = tgt;
    end
    x.adel = x.flush && (x.npc[1:0] != 2'b00);
    sb.push_back(x);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input bit st, input int n);
    for (int i = 0; i < n; i++) step(1'b0, st, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  initial begin
    rst = 1'b1; if_stall = 1'b0; br_valid = 1'b0; br_target = '0;
    exc_valid = 1'b0; eret_valid = 1'b0; epc = '0; if_pc = RST_PC;
    pc_m = RST_PC; m_boot = 1'b1; m_held = 1'b0; m_rank = 0; m_tgt = '0;
    @(posedge clk);
    #1;

    // Reset, boot bubble, first sequential fetch.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    idle(1'b0, 2);

    // Unstalled branch redirects in the same cycle.
    pc_m = 32'hBFC0_0010;
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hBFC0_0100, 32'h0);

    // Branch during a 4-cycle stall is held then applied.
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h8000_1000, 32'h0);
    idle(1'b1, 3);
    idle(1'b0, 2);

    // Held branch overridden by exception; held exception ignores later ERET.
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h8000_2000, 32'h0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    idle(1'b0, 1);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h8000_0040);
    idle(1'b0, 1);
    // Same-priority overwrite while held.
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h8000_0100);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h8000_0200);

    // All three at once, ERET+branch pair, and PC+4 wrap.
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h8000_3000, 32'h8000_4000);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h8000_3000, 32'h8000_4000);
    pc_m = 32'hFFFF_FFFC;
    idle(1'b0, 2);

    // Reset while a redirect is pending, including a redirect in the boot cycle.
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h8000_5000, 32'h0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    pc_m = RST_PC;
    idle(1'b0, 2);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    pc_m = RST_PC;
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h8000_6000, 32'h0);
    idle(1'b0, 1);

    // Misaligned branch target is written unmodified.
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h8000_0102, 32'h0);
    idle(1'b0, 1);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      bit r;
      logic [31:0] bt;
      r  = ($urandom_range(0, 99) == 0);
      bt = $urandom();
      if ($urandom_range(0, 3) != 0) bt[1:0] = 2'b00;
      if ($urandom_range(0, 49) == 0) pc_m = $urandom() & 32'hFFFF_FFFC;
      if (r) pc_m = RST_PC;
      step(r, ($urandom_range(0, 9) < 3),
           ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 9) < 2), bt, $urandom() & 32'hFFFF_FFFC);
      if (r) pc_m = RST_PC;
    end

    @(negedge clk);
    @(negedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
